// File: rtl/axi_ram_responder_pkg.sv
// rtl/axi_ram_responder_pkg.sv - shared response, burst and FSM state codes
package axi_ram_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_WRESP = 2'b10;
  localparam logic [1:0] ST_READ  = 2'b11;

  // WRAP and the reserved code are flagged as errors and then run as INCR
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return (burst != BURST_FIXED) && (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_ram_responder_if.sv
// rtl/axi_ram_responder_if.sv - AXI bus bundle between master and RAM responder
interface axi_ram_responder_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   axi_awaddr;
  logic [7:0]          axi_awlen;
  logic [1:0]          axi_awburst;
  logic                axi_awvalid;
  logic                axi_awready;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wlast;
  logic                axi_wvalid;
  logic                axi_wready;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;
  logic [ADDR_W-1:0]   axi_araddr;
  logic [7:0]          axi_arlen;
  logic [1:0]          axi_arburst;
  logic                axi_arvalid;
  logic                axi_arready;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic                axi_rlast;
  logic                axi_rvalid;
  logic                axi_rready;

  modport master (
    output axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

endinterface

// File: rtl/axi_ram_responder_mem.sv
// rtl/axi_ram_responder_mem.sv - single-port byte-enable RAM with registered read
module axi_ram_responder_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // byte-lane writes and a read-before-write registered read port; no reset on storage
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_ram_responder.sv
// rtl/axi_ram_responder.sv - single-outstanding AXI burst responder in front of a word RAM
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  axi_ram_responder_if.slave axi
);

  logic [1:0]            state_q;
  logic                  rr_read_q;   // 1 when read wins the next simultaneous request
  logic [MEM_ADDR_W-1:0] ptr_q;
  logic [7:0]            cnt_q;
  logic [7:0]            len_q;
  logic                  fixed_q;
  logic                  decerr_q;
  logic                  slverr_q;
  logic [1:0]            bresp_q;
  logic                  bvalid_q;
  logic [1:0]            rresp_q;
  logic                  rvalid_q;

  logic                  in_idle;
  logic                  grant_w;
  logic                  grant_r;
  logic                  aw_decerr;
  logic                  ar_decerr;
  logic                  w_beat;
  logic                  last_beat;
  logic                  wlast_err;
  logic                  r_hs;
  logic [MEM_ADDR_W-1:0] ptr_next;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;
  logic [1:0]            wr_final_resp;

  assign in_idle   = (state_q == ST_IDLE);
  assign grant_w   = in_idle && axi.axi_awvalid && (!axi.axi_arvalid || !rr_read_q);
  assign grant_r   = in_idle && axi.axi_arvalid && !grant_w;

  // any start address beyond the RAM decodes to no slave
  assign aw_decerr = |(axi.axi_awaddr >> (MEM_ADDR_W + 2));
  assign ar_decerr = |(axi.axi_araddr >> (MEM_ADDR_W + 2));

  assign last_beat = (cnt_q == len_q);
  assign w_beat    = (state_q == ST_WRITE) && axi.axi_wvalid;
  assign wlast_err = w_beat && (axi.axi_wlast != last_beat);
  assign r_hs      = (state_q == ST_READ) && rvalid_q && axi.axi_rready;
  assign ptr_next  = ptr_q + {{(MEM_ADDR_W-1){1'b0}}, !fixed_q};

  assign wr_final_resp = decerr_q ? RESP_DECERR :
                         (slverr_q || wlast_err) ? RESP_SLVERR : RESP_OKAY;

  // during a read the RAM fetches one beat ahead so rdata flips right after each handshake
  // and simply holds while the master stalls
  assign mem_addr = (state_q == ST_WRITE) ? ptr_q : (r_hs ? ptr_next : ptr_q);
  assign mem_we   = w_beat && !decerr_q;

  axi_ram_responder_mem #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .en    (1'b1),
    .we    (mem_we),
    .be    (axi.axi_wstrb),
    .addr  (mem_addr),
    .wdata (axi.axi_wdata),
    .rdata (mem_rdata)
  );

  // grants are gated by reset so nothing is accepted while the block is held
  assign axi.axi_awready = rst && grant_w;
  assign axi.axi_arready = rst && grant_r;
  assign axi.axi_wready  = (state_q == ST_WRITE);
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rresp   = rvalid_q ? rresp_q : RESP_OKAY;
  assign axi.axi_rlast   = rvalid_q && last_beat;
  assign axi.axi_rdata   = (rvalid_q && !decerr_q) ? mem_rdata : '0;

  // burst FSM: accept one request, run its beats, respond, return to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rr_read_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      decerr_q  <= 1'b0;
      slverr_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_w) begin
            state_q   <= ST_WRITE;
            rr_read_q <= 1'b1;
            ptr_q     <= axi.axi_awaddr[MEM_ADDR_W+1:2];
            len_q     <= axi.axi_awlen;
            cnt_q     <= '0;
            fixed_q   <= (axi.axi_awburst == BURST_FIXED);
            decerr_q  <= aw_decerr;
            slverr_q  <= burst_unsupported(axi.axi_awburst);
          end else if (grant_r) begin
            state_q   <= ST_READ;
            rr_read_q <= 1'b0;
            ptr_q     <= axi.axi_araddr[MEM_ADDR_W+1:2];
            len_q     <= axi.axi_arlen;
            cnt_q     <= '0;
            fixed_q   <= (axi.axi_arburst == BURST_FIXED);
            decerr_q  <= ar_decerr;
            slverr_q  <= burst_unsupported(axi.axi_arburst);
            rresp_q   <= ar_decerr ? RESP_DECERR :
                         burst_unsupported(axi.axi_arburst) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_WRITE: begin
          if (w_beat) begin
            ptr_q <= ptr_next;
            cnt_q <= cnt_q + 8'd1;
            if (wlast_err) slverr_q <= 1'b1;
            if (last_beat) begin
              state_q  <= ST_WRESP;
              bvalid_q <= 1'b1;
              bresp_q  <= wr_final_resp;
            end
          end
        end
        ST_WRESP: begin
          if (axi.axi_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            state_q  <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (axi.axi_rready) begin
            ptr_q <= ptr_next;
            cnt_q <= cnt_q + 8'd1;
            if (last_beat) begin
              rvalid_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// tb/tb_axi_ram_responder.sv - directed self-checking bench for axi_ram_responder
module tb_axi_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_ram_responder_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  axi_ram_responder #(
    .ADDR_W     (24),
    .DATA_W     (32),
    .MEM_ADDR_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .axi (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_data  [0:15];
  logic [31:0] exp_data [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic aw_req(input logic [23:0] a, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    @(negedge clk);
    bus.axi_awaddr  = a;
    bus.axi_awlen   = l;
    bus.axi_awburst = b;
    bus.axi_awvalid = 1'b1;
    #1;
    while (!bus.axi_awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("aw_grant", 32'(bus.axi_awready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
  endtask

  task automatic w_beats(input int len, input logic [3:0] strb, input int wlast_at);
    int n;
    int stuck = 0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      bus.axi_wvalid = 1'b1;
      bus.axi_wdata  = wr_data[i];
      bus.axi_wstrb  = strb;
      bus.axi_wlast  = (i == wlast_at);
      #1;
      n = 0;
      while (!bus.axi_wready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      if (!bus.axi_wready) stuck++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    #1;
    check("w_accept", 32'(stuck), 32'd0);
    check("w_exit", 32'(bus.axi_wready), 32'd0);
  endtask

  task automatic b_resp(input string tag, input logic [1:0] exp);
    int n = 0;
    @(negedge clk);
    bus.axi_bready = 1'b1;
    #1;
    while (!bus.axi_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("b_valid", 32'(bus.axi_bvalid), 32'd1);
    check(tag, 32'(bus.axi_bresp), 32'(exp));
    @(posedge clk);
    @(negedge clk);
    bus.axi_bready = 1'b0;
    #1;
    check("b_clear", 32'(bus.axi_bvalid), 32'd0);
  endtask

  task automatic ar_req(input logic [23:0] a, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    @(negedge clk);
    bus.axi_araddr  = a;
    bus.axi_arlen   = l;
    bus.axi_arburst = b;
    bus.axi_arvalid = 1'b1;
    #1;
    while (!bus.axi_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("ar_grant", 32'(bus.axi_arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    #1;
    check("r_lat_gap", 32'(bus.axi_rvalid), 32'd0);
  endtask

  // toggle=1 drives rready as 1,0,0,1,0,0,... starting with the first valid cycle
  task automatic read_beats(input int len, input bit toggle, input logic [1:0] exp_resp);
    int beat = 0;
    int cyc  = 0;
    logic stalled = 1'b0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    while (beat <= len && cyc < 100) begin
      @(negedge clk);
      bus.axi_rready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (cyc == 0) check("r_first_valid", 32'(bus.axi_rvalid), 32'd1);
      if (bus.axi_rvalid) begin
        if (stalled) begin
          check("r_hold_data", bus.axi_rdata, hd);
          check("r_hold_last", 32'(bus.axi_rlast), 32'(hl));
        end
        if (bus.axi_rready) begin
          check("r_data", bus.axi_rdata, exp_data[beat]);
          check("r_last", 32'(bus.axi_rlast), 32'(beat == len));
          check("r_resp", 32'(bus.axi_rresp), 32'(exp_resp));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = bus.axi_rdata;
          hl = bus.axi_rlast;
        end
      end
      @(posedge clk);
      cyc++;
    end
    check("r_count", 32'(beat), 32'(len + 1));
    @(negedge clk);
    bus.axi_rready = 1'b0;
    #1;
    check("r_done", 32'(bus.axi_rvalid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(bus.axi_awready), 32'd0);
    check({tag, "_arready"}, 32'(bus.axi_arready), 32'd0);
    check({tag, "_wready"},  32'(bus.axi_wready),  32'd0);
    check({tag, "_bvalid"},  32'(bus.axi_bvalid),  32'd0);
    check({tag, "_bresp"},   32'(bus.axi_bresp),   32'd0);
    check({tag, "_rvalid"},  32'(bus.axi_rvalid),  32'd0);
    check({tag, "_rresp"},   32'(bus.axi_rresp),   32'd0);
    check({tag, "_rlast"},   32'(bus.axi_rlast),   32'd0);
    check({tag, "_rdata"},   bus.axi_rdata,        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b0;
    bus.axi_wdata  = '0; bus.axi_wstrb = '0; bus.axi_wlast  = 1'b0;   bus.axi_wvalid  = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arburst = 2'b01; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;

    // held in reset with both requests pending: nothing may be granted
    repeat (2) @(negedge clk);
    bus.axi_awvalid = 1'b1;
    bus.axi_arvalid = 1'b1;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    bus.axi_arvalid = 1'b0;
    rst = 1'b1;

    // simultaneous write and read after reset: write first, read in the next IDLE
    @(negedge clk);
    bus.axi_awaddr = 24'h000200; bus.axi_awlen = 8'd0; bus.axi_awburst = 2'b01;
    bus.axi_araddr = 24'h000200; bus.axi_arlen = 8'd0; bus.axi_arburst = 2'b01;
    bus.axi_awvalid = 1'b1;
    bus.axi_arvalid = 1'b1;
    #1;
    check("rr_aw_first", 32'(bus.axi_awready), 32'd1);
    check("rr_ar_wait",  32'(bus.axi_arready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    #1;
    check("rr_ar_in_write", 32'(bus.axi_arready), 32'd0);
    wr_data[0] = 32'h00000055;
    w_beats(0, 4'hF, 0);
    b_resp("rr_bresp", 2'b00);
    n = 0;
    while (!bus.axi_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("rr_ar_next", 32'(bus.axi_arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    exp_data[0] = 32'h00000055;
    read_beats(0, 1'b0, 2'b00);

    // 4-beat burst write then read back
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + i;
    aw_req(24'h000100, 8'd3, 2'b01);
    w_beats(3, 4'hF, 3);
    b_resp("burst4_bresp", 2'b00);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
    ar_req(24'h000100, 8'd3, 2'b01);
    read_beats(3, 1'b0, 2'b00);

    // partial byte-lane write merges with existing word
    wr_data[0] = 32'h11223344;
    aw_req(24'h000000, 8'd0, 2'b01);
    w_beats(0, 4'hF, 0);
    b_resp("full_bresp", 2'b00);
    wr_data[0] = 32'hFFFFFFFF;
    aw_req(24'h000000, 8'd0, 2'b01);
    w_beats(0, 4'h5, 0);
    b_resp("strb_bresp", 2'b00);
    exp_data[0] = 32'h11FF33FF;
    ar_req(24'h000000, 8'd0, 2'b01);
    read_beats(0, 1'b0, 2'b00);

    // out-of-range address: DECERR, no write, zero read data
    wr_data[0] = 32'hDEADBEEF;
    aw_req(24'h040000, 8'd0, 2'b01);
    w_beats(0, 4'hF, 0);
    b_resp("decerr_bresp", 2'b11);
    exp_data[0] = 32'h0;
    ar_req(24'h040000, 8'd0, 2'b01);
    read_beats(0, 1'b0, 2'b11);
    exp_data[0] = 32'h11FF33FF;
    ar_req(24'h000000, 8'd0, 2'b01);
    read_beats(0, 1'b0, 2'b00);

    // 8-beat read with master stalls
    for (int i = 0; i < 8; i++) wr_data[i] = 32'hC0 + i;
    aw_req(24'h000300, 8'd7, 2'b01);
    w_beats(7, 4'hF, 7);
    b_resp("burst8_bresp", 2'b00);
    for (int i = 0; i < 8; i++) exp_data[i] = 32'hC0 + i;
    ar_req(24'h000300, 8'd7, 2'b01);
    read_beats(7, 1'b1, 2'b00);

    // early wlast still runs all four beats, then SLVERR
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0 + i;
    aw_req(24'h000400, 8'd3, 2'b01);
    w_beats(3, 4'hF, 1);
    b_resp("early_wlast_bresp", 2'b10);

    // missing wlast on the final beat
    aw_req(24'h000400, 8'd1, 2'b01);
    w_beats(1, 4'hF, 99);
    b_resp("no_wlast_bresp", 2'b10);

    // WRAP burst: SLVERR but data laid out as INCR
    wr_data[0] = 32'h00000001;
    wr_data[1] = 32'h00000002;
    aw_req(24'h000500, 8'd1, 2'b10);
    w_beats(1, 4'hF, 1);
    b_resp("wrap_bresp", 2'b10);
    exp_data[0] = 32'h00000001;
    exp_data[1] = 32'h00000002;
    ar_req(24'h000500, 8'd1, 2'b01);
    read_beats(1, 1'b0, 2'b00);

    // burst crossing the top word wraps to word 0
    wr_data[0] = 32'h00000077;
    wr_data[1] = 32'h00000088;
    aw_req(24'h03FFFC, 8'd1, 2'b01);
    w_beats(1, 4'hF, 1);
    b_resp("topwrap_bresp", 2'b00);
    exp_data[0] = 32'h00000088;
    ar_req(24'h000000, 8'd0, 2'b01);
    read_beats(0, 1'b0, 2'b00);

    // reset asserted mid-read aborts at once
    ar_req(24'h000300, 8'd7, 2'b01);
    repeat (3) begin
      @(negedge clk);
      bus.axi_rready = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;

    // next burst after the abort completes normally
    wr_data[0] = 32'h00000099;
    aw_req(24'h000600, 8'd0, 2'b01);
    w_beats(0, 4'hF, 0);
    b_resp("post_rst_bresp", 2'b00);
    exp_data[0] = 32'h00000099;
    ar_req(24'h000600, 8'd0, 2'b01);
    read_beats(0, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
